// File: rtl/mdr_pkg.sv
// mdr_pkg: shared types and constants for the MDR datapath result demux
package mdr_pkg;
  localparam int DW = 16;
  localparam int DW_DBL = 2 * DW;
  localparam int MDR_NCH = 3;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;
  typedef logic [DW_DBL:0] mdr_word_t;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/mdr_demux_slot.sv
// mdr_demux_slot: one-entry output holding slot with valid/ready handshake.
// MDR_DEMUX_CNT_EN adds a wrapping 16-bit delivered-word counter.
module mdr_demux_slot import mdr_pkg::*; #(
  parameter int DATA_W = DW_DBL + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
`ifdef MDR_DEMUX_CNT_EN
  ,
  output logic [15:0]       o_cnt
`endif
);
  slot_state_t r_state;
  logic [DATA_W-1:0] r_data;
  // a load is only issued when the slot is empty or draining this cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= SLOT_FULL;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_state <= SLOT_EMPTY;
    end
  assign o_valid = r_state == SLOT_FULL;
  assign o_data  = r_data;
`ifdef MDR_DEMUX_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (o_valid & i_ready) r_cnt <= r_cnt + 16'd1;
  assign o_cnt = r_cnt;
`endif
endmodule

// File: rtl/mdr_result_demux.sv
// mdr_result_demux: routes MDR result words to one of three slotted channels.
// MDR_DEMUX_CNT_EN adds per-channel delivered-word counters on dlv_cnt.
module mdr_result_demux import mdr_pkg::*; #(
  parameter int DATA_W = DW_DBL + 1,
  parameter int NCH    = MDR_NCH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_sel,
  input  logic [DATA_W-1:0]          in_data,
  output logic [NCH-1:0]             out_valid,
  input  logic [NCH-1:0]             out_ready,
  output logic [NCH-1:0][DATA_W-1:0] out_data,
  output logic                       err_pulse,
  output logic                       err_sticky,
  input  logic                       err_clr
`ifdef MDR_DEMUX_CNT_EN
  ,
  output logic [NCH-1:0][15:0]       dlv_cnt
`endif
);
  logic w_illegal, w_accept;
  logic [NCH-1:0] w_hit;
  logic r_err_pulse, r_err_sticky;
  assign w_illegal = in_sel == SEL_ILLEGAL;
  // illegal words are always taken so they can be discarded without stalling
  assign in_ready  = w_illegal | (|(w_hit & (~out_valid | out_ready)));
  assign w_accept  = in_valid & in_ready;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_hit[c] = in_sel == 2'(c);
    mdr_demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept & w_hit[c]),
      .i_data  (in_data),
      .i_ready (out_ready[c]),
      .o_valid (out_valid[c]),
      .o_data  (out_data[c])
`ifdef MDR_DEMUX_CNT_EN
      ,
      .o_cnt   (dlv_cnt[c])
`endif
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse  <= w_accept & w_illegal;
      r_err_sticky <= (w_accept & w_illegal) | (r_err_sticky & ~err_clr);
    end
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
endmodule
